// File: rtl/nand_loader_pkg.sv
// Shared types and constants for the nand_cpu byte-stream boot/debug loader.
package nand_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_LEN       = 4'd2,
    S_DATA      = 4'd3,
    S_RD_REQ    = 4'd4,
    S_RD_WAIT   = 4'd5,
    S_TX        = 4'd6,
    S_RUN_START = 4'd7,
    S_RUN_WAIT  = 4'd8,
    S_ACK       = 4'd9
  } state_t;

  localparam logic [7:0] CMD_WR_I = 8'h01;
  localparam logic [7:0] CMD_WR_D = 8'h02;
  localparam logic [7:0] CMD_RD_D = 8'h03;
  localparam logic [7:0] CMD_RUN  = 8'h04;

  localparam logic [7:0] ST_OK      = 8'hA5;
  localparam logic [7:0] ST_BADCMD  = 8'hEE;
  localparam logic [7:0] ST_TIMEOUT = 8'hE7;

  // A length byte of zero encodes a full 256-byte burst.
  function automatic logic [8:0] burst_len(input logic [7:0] len_byte);
    return (len_byte == 8'h00) ? 9'd256 : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/loader_tx_reg.sv
// One-entry holding register for the loader's return byte channel.
module loader_tx_reg (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] dout
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid <= 1'b0;
      dout  <= 8'h00;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nand_mem_loader.sv
// Host byte-stream loader for nand_cpu: fills I_MEM/D_MEM, runs the CPU until halt, reads D_MEM back.
// Optional RUN watchdog enabled by defining LOADER_TIMEOUT_EN.
module nand_mem_loader
  import nand_loader_pkg::*;
#(
  parameter int I_ADDR_W = 8,
  parameter int D_ADDR_W = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic                cpu_n_rst,
  input  logic                cpu_halt,
  output logic                mem_owner,
  output logic                imem_we,
  output logic [I_ADDR_W-1:0] imem_addr,
  output logic [7:0]          imem_wdata,
  output logic                dmem_we,
  output logic [D_ADDR_W-1:0] dmem_addr,
  output logic [7:0]          dmem_wdata,
  input  logic [7:0]          dmem_rdata
);

  localparam int AW = (I_ADDR_W > D_ADDR_W) ? I_ADDR_W : D_ADDR_W;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("nand_mem_loader: TIMEOUT must be at least 1");
  end

  state_t        state, state_nxt;
  logic          live;
  logic [7:0]    cmd;
  logic [AW-1:0] addr;
  logic [8:0]    cnt;
  logic          rx_fire, tx_fire;
  logic          tx_load;
  logic [7:0]    tx_din;
  logic          run_end;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

  // live keeps rx_ready low while reset is asserted even though the state reads IDLE
  assign rx_ready = live && !tx_valid &&
                    (state == S_IDLE || state == S_ADDR || state == S_LEN || state == S_DATA);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_expired;

  assign wd_expired = (wd_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                  wd_cnt <= 32'd0;
    else if (state == S_RUN_WAIT) wd_cnt <= wd_cnt + 32'd1;
    else                         wd_cnt <= 32'd0;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    tx_din    = 8'h00;
    run_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            CMD_WR_I, CMD_WR_D, CMD_RD_D: state_nxt = S_ADDR;
            CMD_RUN:                      state_nxt = S_RUN_START;
            default: begin
              tx_load   = 1'b1;
              tx_din    = ST_BADCMD;
              state_nxt = S_ACK;
            end
          endcase
        end
      end
      S_ADDR: if (rx_fire) state_nxt = S_LEN;
      S_LEN:  if (rx_fire) state_nxt = (cmd == CMD_RD_D) ? S_RD_REQ : S_DATA;
      S_DATA: begin
        if (rx_fire && cnt == 9'd1) begin
          tx_load   = 1'b1;
          tx_din    = ST_OK;
          state_nxt = S_ACK;
        end
      end
      S_RD_REQ: state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        tx_load   = 1'b1;
        tx_din    = dmem_rdata;
        state_nxt = S_TX;
      end
      S_TX: if (tx_fire) state_nxt = (cnt == 9'd0) ? S_IDLE : S_RD_REQ;
      // halt seen here would be the pre-release value, so it is skipped
      S_RUN_START: state_nxt = S_RUN_WAIT;
      S_RUN_WAIT: begin
        if (cpu_halt) begin
          tx_load   = 1'b1;
          tx_din    = ST_OK;
          run_end   = 1'b1;
          state_nxt = S_ACK;
        end
`ifdef LOADER_TIMEOUT_EN
        else if (wd_expired) begin
          tx_load   = 1'b1;
          tx_din    = ST_TIMEOUT;
          run_end   = 1'b1;
          state_nxt = S_ACK;
        end
`endif
      end
      S_ACK:   if (tx_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      live       <= 1'b0;
      cmd        <= 8'h00;
      addr       <= '0;
      cnt        <= 9'd0;
      cpu_n_rst  <= 1'b0;
      mem_owner  <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 8'h00;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 8'h00;
    end else begin
      live    <= 1'b1;
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            cmd <= rx_data;
            if (rx_data == CMD_RUN) begin
              cpu_n_rst <= 1'b1;
              mem_owner <= 1'b0;
            end
          end
        end
        S_ADDR: if (rx_fire) addr <= AW'(rx_data);
        S_LEN: begin
          if (rx_fire) begin
            cnt <= burst_len(rx_data);
            if (cmd == CMD_RD_D) dmem_addr <= addr[D_ADDR_W-1:0];
          end
        end
        // write strobe lands one cycle after the byte is taken, then the address advances
        S_DATA: begin
          if (rx_fire) begin
            if (cmd == CMD_WR_I) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr[I_ADDR_W-1:0];
              imem_wdata <= rx_data;
            end else begin
              dmem_we    <= 1'b1;
              dmem_addr  <= addr[D_ADDR_W-1:0];
              dmem_wdata <= rx_data;
            end
            addr <= addr + AW'(1);
            cnt  <= cnt - 9'd1;
          end
        end
        S_RD_WAIT: begin
          addr <= addr + AW'(1);
          cnt  <= cnt - 9'd1;
        end
        S_TX: if (tx_fire && cnt != 9'd0) dmem_addr <= addr[D_ADDR_W-1:0];
        S_RUN_WAIT: begin
          if (run_end) begin
            cpu_n_rst <= 1'b0;
            mem_owner <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  loader_tx_reg u_tx (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (tx_load),
    .din   (tx_din),
    .valid (tx_valid),
    .ready (tx_ready),
    .dout  (tx_data)
  );

endmodule

// File: tb/tb_nand_mem_loader.sv
// Self-checking bench for nand_mem_loader: memory/CPU responder, expectation queues, per-cycle compare.
`timescale 1ns/1ps
module tb_nand_mem_loader;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       cpu_n_rst;
  logic       cpu_halt;
  logic       mem_owner;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic [7:0] dmem_rdata;

  nand_mem_loader #(.I_ADDR_W(8), .D_ADDR_W(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .cpu_n_rst  (cpu_n_rst),
    .cpu_halt   (cpu_halt),
    .mem_owner  (mem_owner),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  initial forever #5 clk = ~clk;

  // Memories plus a stand-in CPU: once released and enabled it runs the 16-bit add
  // (D[5:4] = D[1:0] + D[3:2]) a few cycles later and raises halt.
  logic [7:0]  imem_mem [256];
  logic [7:0]  dmem_mem [256];
  logic [15:0] cpu_sum;
  int          cpu_cyc = 0;
  bit          cpu_en;

  assign cpu_sum = {dmem_mem[1], dmem_mem[0]} + {dmem_mem[3], dmem_mem[2]};

  always @(posedge clk) begin
    if (imem_we) imem_mem[imem_addr] <= imem_wdata;
    if (dmem_we) dmem_mem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dmem_mem[dmem_addr];
    if (!cpu_n_rst) begin
      cpu_cyc  <= 0;
      cpu_halt <= 1'b0;
    end else begin
      cpu_cyc <= cpu_cyc + 1;
      if (cpu_en && cpu_cyc >= 8 && !cpu_halt) begin
        dmem_mem[4] <= cpu_sum[7:0];
        dmem_mem[5] <= cpu_sum[15:8];
        cpu_halt    <= 1'b1;
      end
    end
  end

  typedef struct {
    bit         is_d;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  typedef logic [7:0] bq_t [$];

  int         checks = 0;
  int         errors = 0;
  wr_t        exp_w [$];
  logic [7:0] exp_tx [$];
  logic [7:0] rx_log [$];
  logic [7:0] ref_d [256];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         saw_rx_fire = 1'b0;
  int         imem_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare();
    wr_t e;
    saw_rx_fire = rx_valid && rx_ready;
    if (prev_stall) begin
      chk("tx_hold_valid", 32'(tx_valid), 32'd1);
      chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
    end
    if (!mem_owner) chk("owner_we", 32'({imem_we, dmem_we}), 32'd0);
    if (imem_we || dmem_we) begin
      if (imem_we) imem_writes++;
      chk("we_pending", 32'(exp_w.size() > 0), 32'd1);
      if (exp_w.size() > 0) begin
        e = exp_w.pop_front();
        chk("we_target", 32'(dmem_we), 32'(e.is_d));
        chk("we_addr", 32'(e.is_d ? dmem_addr : imem_addr), 32'(e.addr));
        chk("we_data", 32'(e.is_d ? dmem_wdata : imem_wdata), 32'(e.data));
      end
    end
    if (tx_valid && tx_ready) begin
      chk("tx_pending", 32'(exp_tx.size() > 0), 32'd1);
      if (exp_tx.size() > 0) chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      rx_log.push_back(tx_data);
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = saw_rx_fire;
    end
    chk("rx_accept", 32'(done), 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_w.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(exp_tx.size() + exp_w.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic expect_writes(input bit is_d, input logic [7:0] addr, input bq_t data);
    logic [7:0] a;
    wr_t        e;
    a = addr;
    foreach (data[i]) begin
      e.is_d = is_d;
      e.addr = a;
      e.data = data[i];
      exp_w.push_back(e);
      if (is_d) ref_d[a] = data[i];
      a = a + 8'd1;
    end
  endtask

  task automatic wr_cmd(input bit is_d, input logic [7:0] addr, input bq_t data);
    expect_writes(is_d, addr, data);
    exp_tx.push_back(8'hA5);
    send_byte(is_d ? 8'h02 : 8'h01);
    send_byte(addr);
    send_byte(8'(data.size()));
    foreach (data[i]) send_byte(data[i]);
    drain();
  endtask

  task automatic rd_cmd(input logic [7:0] addr, input int n);
    for (int i = 0; i < n; i++) exp_tx.push_back(ref_d[8'(int'(addr) + i)]);
    send_byte(8'h03);
    send_byte(addr);
    send_byte(8'(n));
    drain();
  endtask

  initial begin
    bq_t        q;
    int         n;
    int         base;
    logic [15:0] sum;
    n_rst    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    cpu_en   = 1'b1;

    #20;
    chk("rst_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
    chk("rst_mem_owner", 32'(mem_owner), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'({imem_we, dmem_we}), 32'd0);
    chk("rst_addr", 32'({imem_addr, dmem_addr}), 32'd0);
    #15;
    chk("rst_we_late", 32'({imem_we, dmem_we}), 32'd0);
    #6 n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Operands 0x1234 and 0xABCD
    q = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    wr_cmd(1'b1, 8'h00, q);
    chk("wrd_mem0", 32'(dmem_mem[0]), 32'h34);
    chk("wrd_mem1", 32'(dmem_mem[1]), 32'h12);
    chk("wrd_mem2", 32'(dmem_mem[2]), 32'hCD);
    chk("wrd_mem3", 32'(dmem_mem[3]), 32'hAB);
    chk("wrd_ack", 32'(rx_log[0]), 32'hA5);

    // Program image
    q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'hFF};
    wr_cmd(1'b0, 8'h00, q);
    foreach (q[i]) chk("prog_image", 32'(imem_mem[i]), 32'(q[i]));

`ifdef LOADER_TIMEOUT_EN
    cpu_en = 1'b0;
    exp_tx.push_back(8'hE7);
    send_byte(8'h04);
    n = 0;
    while (!tx_valid && n < 40) begin
      tick();
      n++;
    end
    chk("wd_fired", 32'(tx_valid), 32'd1);
    chk("wd_window", 32'(n >= 16 && n <= 18), 32'd1);
    chk("wd_status", 32'(tx_data), 32'hE7);
    chk("wd_cpu_rst", 32'(cpu_n_rst), 32'd0);
    chk("wd_owner", 32'(mem_owner), 32'd1);
    drain();
`endif

    // RUN: CPU held running for a while, then allowed to halt
    cpu_en = 1'b0;
    send_byte(8'h04);
    chk("run_cpu_rel", 32'(cpu_n_rst), 32'd1);
    chk("run_owner", 32'(mem_owner), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("run_wait_tx", 32'(tx_valid), 32'd0);
    chk("run_wait_cpu", 32'(cpu_n_rst), 32'd1);
    sum = {ref_d[1], ref_d[0]} + {ref_d[3], ref_d[2]};
    ref_d[4] = sum[7:0];
    ref_d[5] = sum[15:8];
    exp_tx.push_back(8'hA5);
    cpu_en = 1'b1;
    drain();
    chk("halt_cpu_rst", 32'(cpu_n_rst), 32'd0);
    chk("halt_owner", 32'(mem_owner), 32'd1);
    chk("halt_status", 32'(rx_log[rx_log.size() - 1]), 32'hA5);

    rd_cmd(8'h04, 2);
    chk("sum_lo", 32'(rx_log[rx_log.size() - 2]), 32'h01);
    chk("sum_hi", 32'(rx_log[rx_log.size() - 1]), 32'hBE);

    // D_MEM wrap on write and read
    q = '{8'h9A, 8'hBC, 8'h77};
    wr_cmd(1'b1, 8'hFE, q);
    rd_cmd(8'hFE, 4);

    // I_MEM wrap, then a full 256-byte burst
    q = '{8'h5A, 8'hC3};
    wr_cmd(1'b0, 8'hFF, q);
    chk("iwrap_ff", 32'(imem_mem[8'hFF]), 32'h5A);
    chk("iwrap_00", 32'(imem_mem[8'h00]), 32'hC3);
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(8'(i * 3 + 1));
    base = imem_writes;
    wr_cmd(1'b0, 8'h10, q);
    chk("burst256_count", 32'(imem_writes - base), 32'd256);
    chk("burst256_first", 32'(imem_mem[8'h10]), 32'h01);
    chk("burst256_last", 32'(imem_mem[8'h0F]), 32'hFE);

    // Bad command under tx back-pressure
    tx_ready = 1'b0;
    exp_tx.push_back(8'hEE);
    send_byte(8'h7F);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'hEE);
      chk("stall_rx_ready", 32'(rx_ready), 32'd0);
    end
    tx_ready = 1'b1;
    drain();
    rd_cmd(8'h00, 1);

    // Async reset in the middle of a D_MEM load keeps the bytes already written
    q = '{8'h61, 8'h62};
    expect_writes(1'b1, 8'h20, q);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h04);
    send_byte(8'h61);
    send_byte(8'h62);
    tick();
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_cpu", 32'(cpu_n_rst), 32'd0);
    chk("midrst_owner", 32'(mem_owner), 32'd1);
    chk("midrst_tx", 32'(tx_valid), 32'd0);
    chk("midrst_we", 32'({imem_we, dmem_we}), 32'd0);
    chk("midrst_left", 32'(exp_w.size()), 32'd0);
    #3 n_rst = 1'b1;
    @(posedge clk);
    #1;
    rd_cmd(8'h20, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
